// File: rtl/read_string_engine_pkg.sv
// read_string_engine_pkg
//   Shared definitions for the read_string syscall engine: FSM state
//   encoding and the character constants used for termination.
//   No ports.
package read_string_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_TERM    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
  localparam logic [7:0] CHAR_NUL     = 8'h00;

endpackage

// File: rtl/read_string_engine_if.sv
// read_string_engine_if
//   Bundles the syscall request, character stream, memory write port and
//   status outputs of read_string_engine.
//   master : requester side (drives start/base_addr/max_len/char_*).
//   slave  : engine side (drives char_ready, mem_*, busy, done,
//            char_count, echo_*).
interface read_string_engine_if;

  logic        start;
  logic [31:0] base_addr;
  logic [31:0] max_len;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [31:0] char_count;
  logic        echo_valid;
  logic [7:0]  echo_data;

  modport master (
    output start, base_addr, max_len, char_valid, char_data,
    input  char_ready, mem_write, mem_addr, mem_wdata, busy, done,
           char_count, echo_valid, echo_data
  );

  modport slave (
    input  start, base_addr, max_len, char_valid, char_data,
    output char_ready, mem_write, mem_addr, mem_wdata, busy, done,
           char_count, echo_valid, echo_data
  );

endinterface

// File: rtl/read_string_engine_string_packer.sv
// string_packer
//   Packs bytes little-endian into a 32-bit word.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart at byte 0 with an empty word
//   push       : store byte_in at the current byte position
//   byte_in    : byte to store (or to preview in word_out)
//   full       : current position is byte 3 (next push completes a word)
//   word_out   : accumulated word with byte_in merged at the current position
module string_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic        full,
  output logic [31:0] word_out
);

  logic [1:0]  byte_idx;
  logic [31:0] acc;

  // Bytes at and above byte_idx are always zero, so OR-merging is exact.
  assign word_out = acc | ({24'd0, byte_in} << {byte_idx, 3'b000});
  assign full     = (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      byte_idx <= 2'd0;
      acc      <= 32'd0;
    end else if (push) begin
      byte_idx <= byte_idx + 2'd1;
      acc      <= full ? 32'd0 : word_out;
    end
  end

endmodule

// File: rtl/read_string_engine.sv
// read_string_engine
//   Collects a character stream into a word-addressed buffer, terminating
//   on newline (stored) or when the buffer has room only for the NUL, then
//   writes the NUL-terminated final word.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : read_string_engine_if.slave (request, char stream, memory
//           write port, busy/done/char_count, echo)
//   Build option: READ_STRING_ECHO_EN enables the echo_valid/echo_data port;
//   otherwise both are tied to 0.
//
//   state   | meaning
//   IDLE    | waiting for start
//   COLLECT | accepting characters, writing each completed word
//   TERM    | merging NUL into the next byte position
//   FLUSH   | writing the NUL-terminated word
//   DONE    | one-cycle done pulse
module read_string_engine
  import read_string_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  read_string_engine_if.slave   bus
);

  state_t      state_q, state_d;
  logic [31:0] base_q, max_len_q, word_idx_q, count_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        char_ready;
  logic        start_ok, accept, at_limit, last_byte;
  logic        pk_full;
  logic [31:0] pk_word;
  logic [7:0]  pk_byte;

  assign start_ok  = (state_q == ST_IDLE) && bus.start;
  assign accept    = bus.char_valid && char_ready;
  // Only reached in COLLECT, where max_len_q >= 1, so the subtraction is safe.
  assign at_limit  = (count_q == max_len_q - 32'd1);
  assign last_byte = accept && ((bus.char_data == CHAR_NEWLINE) ||
                                (count_q + 32'd1 == max_len_q - 32'd1));
  assign pk_byte   = (state_q == ST_TERM) ? CHAR_NUL : bus.char_data;

  string_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .push     (accept),
    .byte_in  (pk_byte),
    .full     (pk_full),
    .word_out (pk_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = (bus.max_len == 32'd0) ? ST_DONE : ST_COLLECT;
      ST_COLLECT: if (at_limit || last_byte) state_d = ST_TERM;
      ST_TERM:    state_d = ST_FLUSH;
      ST_FLUSH:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    char_ready = (state_q == ST_COLLECT) && !at_limit;
    bus.busy   = (state_q != ST_IDLE);
    bus.done   = (state_q == ST_DONE);
  end

  assign bus.char_ready = char_ready;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.char_count = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q      <= 32'd0;
      max_len_q   <= 32'd0;
      word_idx_q  <= 32'd0;
      count_q     <= 32'd0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      mem_write_q <= 1'b0;
      if (start_ok) begin
        base_q     <= bus.base_addr;
        max_len_q  <= bus.max_len;
        word_idx_q <= 32'd0;
        count_q    <= 32'd0;
      end
      if (accept) begin
        count_q <= count_q + 32'd1;
        if (pk_full) begin
          mem_write_q <= 1'b1;
          mem_addr_q  <= base_q + word_idx_q;
          mem_wdata_q <= pk_word;
          word_idx_q  <= word_idx_q + 32'd1;
        end
      end
      // A word completed by the terminating byte was written last cycle and
      // word_idx_q has already advanced, so the NUL lands in a fresh word.
      if (state_q == ST_TERM) begin
        mem_write_q <= 1'b1;
        mem_addr_q  <= base_q + word_idx_q;
        mem_wdata_q <= pk_word;
      end
    end
  end

`ifdef READ_STRING_ECHO_EN
  logic       echo_valid_q;
  logic [7:0] echo_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'd0;
    end else begin
      echo_valid_q <= accept;
      if (accept) echo_data_q <= bus.char_data;
    end
  end

  assign bus.echo_valid = echo_valid_q;
  assign bus.echo_data  = echo_data_q;
`else
  assign bus.echo_valid = 1'b0;
  assign bus.echo_data  = 8'd0;
`endif

endmodule
